// File: rtl/rx_fifo_ctrl.sv
`default_nettype none
// ---- rx_fifo_ctrl : UART RX byte FIFO with rdy/clr handshake, occupancy flags and irq (rev 1.0) ----

module rx_fifo_ctrl #(
  parameter int DEPTH  = 8,
  parameter int THRESH = 4
) (
  input  logic                     clk_50m,
  input  logic                     rst,
  input  logic                     rx_rdy,
  input  logic [7:0]               rx_data,
  output logic                     rdy_clr,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic                     irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0] C_THRESH = CW'(THRESH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CLR  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      mem_q [DEPTH];

  logic            capture;
  logic            rd_fire;
  logic            wr_fire;
  logic            drop;

  // rx_rdy is only looked at in IDLE, so a level held through CLR is never taken twice
  assign capture = (state_q == S_IDLE) && rx_rdy;
  assign rd_fire = rd_en && (count_q != '0);
  assign wr_fire = capture && ((count_q < C_DEPTH) || rd_fire);
  assign drop    = capture && !wr_fire;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rx_rdy) state_d = S_CLR;
      S_CLR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // a drop in the same cycle as ovf_clr must leave the flag set
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!rst && wr_fire) mem_q[wr_ptr_q] <= rx_data;
  end

  assign rdy_clr  = (state_q == S_CLR);
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == C_DEPTH);
  assign irq      = (count_q >= C_THRESH);
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_fifo_ctrl.sv
`default_nettype none
// ---- tb_rx_fifo_ctrl : vector table plus scoreboard sequences for rx_fifo_ctrl (rev 1.0) ----

module tb_rx_fifo_ctrl;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rdy_clr;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;
  logic       ovf_clr = 1'b0;
  logic       irq;

  rx_fifo_ctrl #(.DEPTH(8), .THRESH(4)) dut (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .rx_rdy   (rx_rdy),
    .rx_data  (rx_data),
    .rdy_clr  (rdy_clr),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .irq      (irq)
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [7:0] data;
    logic       rd;
    logic       oclr;
    logic       e_clr;
    int         e_cnt;
    logic       e_ovf;
    logic       e_irq;
    logic       chk_d;
    logic [7:0] e_data;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         mcount = 0;
  logic       movf = 1'b0;

  function automatic vec_t mkv(logic r, logic rdy, logic [7:0] d, logic rd, logic oc,
                               logic ec, int cnt, logic eo, logic ei, logic cd, logic [7:0] ed);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.data = d; v.rd = rd; v.oclr = oc;
    v.e_clr = ec; v.e_cnt = cnt; v.e_ovf = eo; v.e_irq = ei; v.chk_d = cd; v.e_data = ed;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic check_flags(input string tag);
    check({tag, " count"},    int'(count),    mcount);
    check({tag, " empty"},    int'(empty),    int'(mcount == 0));
    check({tag, " full"},     int'(full),     int'(mcount == 8));
    check({tag, " irq"},      int'(irq),      int'(mcount >= 4));
    check({tag, " overflow"}, int'(overflow), int'(movf));
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_rdy = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    cycle();
    rst = 1'b0;
    mcount = 0; movf = 1'b0; sb.delete();
    check("reset rdy_clr", int'(rdy_clr), 0);
    check_flags("reset");
  endtask

  // one receiver byte: capture cycle then the CLR cycle
  task automatic push_byte(input logic [7:0] b, input logic oc);
    rx_rdy = 1'b1; rx_data = b; ovf_clr = oc;
    cycle();
    if (mcount < 8) begin
      sb.push_back(b);
      mcount++;
    end else begin
      movf = 1'b1;
    end
    if (oc && !(mcount == 8 && sb.size() == 8 && movf)) movf = movf;
    check("push rdy_clr", int'(rdy_clr), 1);
    check_flags("push");
    rx_rdy = 1'b0; ovf_clr = 1'b0;
    cycle();
    check("clr end rdy_clr", int'(rdy_clr), 0);
  endtask

  task automatic pop_byte();
    logic [7:0] exp_b;
    if (sb.size() == 0) begin
      check("pop underflow", 1, 0);
      return;
    end
    exp_b = sb.pop_front();
    check("pop rd_data", int'(rd_data), int'(exp_b));
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    mcount--;
    check_flags("pop");
  endtask

  task automatic push_pop(input logic [7:0] b);
    logic [7:0] exp_b;
    exp_b = sb.pop_front();
    check("pushpop rd_data", int'(rd_data), int'(exp_b));
    sb.push_back(b);
    rx_rdy = 1'b1; rx_data = b; rd_en = 1'b1;
    cycle();
    check("pushpop rdy_clr", int'(rdy_clr), 1);
    check_flags("pushpop");
    rx_rdy = 1'b0; rd_en = 1'b0;
    cycle();
  endtask

  initial begin
    // rst rdy data rd oclr | clr cnt ovf irq chk data
    vecs.push_back(mkv(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mkv(1, 1, 8'h99, 1, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mkv(0, 1, 8'hA5, 0, 0, 1, 1, 0, 0, 1, 8'hA5));
    vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 8'hA5));
    vecs.push_back(mkv(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mkv(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mkv(0, 1, 8'h3C, 0, 0, 1, 1, 0, 0, 1, 8'h3C));
    vecs.push_back(mkv(0, 1, 8'h3C, 0, 0, 0, 1, 0, 0, 1, 8'h3C));
    vecs.push_back(mkv(0, 1, 8'h3C, 0, 0, 1, 2, 0, 0, 1, 8'h3C));
    vecs.push_back(mkv(0, 1, 8'h3C, 0, 0, 0, 2, 0, 0, 1, 8'h3C));
    vecs.push_back(mkv(0, 1, 8'h3C, 0, 0, 1, 3, 0, 0, 1, 8'h3C));
    vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 3, 0, 0, 1, 8'h3C));
    vecs.push_back(mkv(0, 1, 8'h11, 1, 0, 1, 3, 0, 0, 1, 8'h3C));
    vecs.push_back(mkv(1, 1, 8'h22, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mkv(0, 1, 8'h22, 0, 0, 1, 1, 0, 0, 1, 8'h22));
    vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 8'h22));
    vecs.push_back(mkv(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00));

    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; rx_rdy = vecs[i].rdy; rx_data = vecs[i].data;
      rd_en = vecs[i].rd; ovf_clr = vecs[i].oclr;
      cycle();
      check($sformatf("vec%0d rdy_clr", i),  int'(rdy_clr),  int'(vecs[i].e_clr));
      check($sformatf("vec%0d count", i),    int'(count),    vecs[i].e_cnt);
      check($sformatf("vec%0d empty", i),    int'(empty),    int'(vecs[i].e_cnt == 0));
      check($sformatf("vec%0d full", i),     int'(full),     int'(vecs[i].e_cnt == 8));
      check($sformatf("vec%0d overflow", i), int'(overflow), int'(vecs[i].e_ovf));
      check($sformatf("vec%0d irq", i),      int'(irq),      int'(vecs[i].e_irq));
      if (vecs[i].chk_d)
        check($sformatf("vec%0d rd_data", i), int'(rd_data), int'(vecs[i].e_data));
    end
    rst = 1'b0; rx_rdy = 1'b0; rd_en = 1'b0;

    // fill to full, drop the 9th byte while ovf_clr is also asserted
    do_reset();
    for (int b = 1; b <= 8; b++) push_byte(8'(b), 1'b0);
    check("fill full", int'(full), 1);
    push_byte(8'h09, 1'b1);
    check("drop overflow set wins", int'(overflow), 1);
    check("drop count", int'(count), 8);
    for (int k = 0; k < 8; k++) pop_byte();
    check("drain empty", int'(empty), 1);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    movf = 1'b0;
    check("ovf_clr overflow", int'(overflow), 0);

    // simultaneous capture and pop while full, across pointer wrap
    for (int b = 0; b < 8; b++) push_byte(8'h10 + 8'(b), 1'b0);
    push_pop(8'h77);
    check("pushpop no overflow", int'(overflow), 0);
    for (int k = 0; k < 8; k++) pop_byte();
    check("pushpop drained", int'(empty), 1);

    // irq threshold
    do_reset();
    for (int b = 0; b < 3; b++) push_byte(8'hC0 + 8'(b), 1'b0);
    check("irq below thresh", int'(irq), 0);
    rx_rdy = 1'b1; rx_data = 8'hC3;
    cycle();
    sb.push_back(8'hC3); mcount++;
    check("irq rises at 4", int'(irq), 1);
    rx_rdy = 1'b0;
    cycle();
    pop_byte();
    check("irq falls at 3", int'(irq), 0);
    while (sb.size() > 0) pop_byte();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
